// File: rtl/float_encoder_tx_pkg.sv
// Shared definitions for the float encoder: IEEE-754 binary32 class codes,
// field constants, FSM state type and a one-hot check helper.
package float_encoder_tx_pkg;

   localparam logic [4:0] t0 = 5'b00001;  // zero
   localparam logic [4:0] t1 = 5'b00010;  // normal
   localparam logic [4:0] t2 = 5'b00100;  // subnormal
   localparam logic [4:0] t3 = 5'b01000;  // infinity
   localparam logic [4:0] t4 = 5'b10000;  // NaN

   localparam logic [7:0]  EXP_MAX      = 8'hFF;
   localparam logic [7:0]  EXP_NORM_MIN = 8'h01;
   localparam logic [7:0]  EXP_NORM_MAX = 8'hFE;
   localparam logic [22:0] QNAN_MAN     = 23'h400000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // x & (x-1) clears the lowest set bit; one-hot leaves nothing behind
   function automatic logic onehot5(input logic [4:0] code);
      return (code != 5'd0) && ((code & (code - 5'd1)) == 5'd0);
   endfunction

endpackage

// File: rtl/float_encoder_tx_if.sv
// Request/response and serial-stream bundle of the float encoder.
interface float_encoder_tx_if;
   import float_encoder_tx_pkg::*;

   logic        start;
   logic [4:0]  type_in;
   logic        sign_in;
   logic [7:0]  exp_in;
   logic [22:0] man_in;
   logic        ready;
   logic [31:0] num_out;
   logic        bit_out;
   logic        bit_valid;
   logic        done;
   logic        err;

   modport master (
      output start, type_in, sign_in, exp_in, man_in,
      input  ready, num_out, bit_out, bit_valid, done, err
   );

   modport slave (
      input  start, type_in, sign_in, exp_in, man_in,
      output ready, num_out, bit_out, bit_valid, done, err
   );
endinterface

// File: rtl/float_encoder_tx_compose.sv
// Combinational composer: builds a canonical binary32 word of the requested
// class from the sign/exponent/mantissa seeds and flags a valid class code.
module float_compose
   import float_encoder_tx_pkg::*;
(
   input  logic [4:0]  type_in,
   input  logic        sign_in,
   input  logic [7:0]  exp_in,
   input  logic [22:0] man_in,
   output logic [31:0] word,
   output logic        onehot_ok
);

   logic [7:0]  exp_s;
   logic [22:0] man_s;

   // Field selection per class; seeds are forced into the legal range of the class
   always_comb begin
      exp_s = 8'h00;
      man_s = 23'd0;
      case (type_in)
         t0: begin
            exp_s = 8'h00;
            man_s = 23'd0;
         end
         t1: begin
            if (exp_in < EXP_NORM_MIN) begin
               exp_s = EXP_NORM_MIN;
            end else if (exp_in > EXP_NORM_MAX) begin
               exp_s = EXP_NORM_MAX;
            end else begin
               exp_s = exp_in;
            end
            man_s = man_in;
         end
         t2: begin
            exp_s = 8'h00;
            man_s = (man_in == 23'd0) ? 23'd1 : man_in;
         end
         t3: begin
            exp_s = EXP_MAX;
            man_s = 23'd0;
         end
         t4: begin
            exp_s = EXP_MAX;
            man_s = (man_in == 23'd0) ? QNAN_MAN : man_in;
         end
         default: begin
            exp_s = 8'h00;
            man_s = 23'd0;
         end
      endcase
   end

   assign word      = {sign_in, exp_s, man_s};
   assign onehot_ok = onehot5(type_in);

endmodule

// File: rtl/float_encoder_tx.sv
// Float encoder top: accepts a class request, latches the composed word and
// shifts it out MSB-first, followed by a one-cycle done pulse.
module float_encoder_tx
   import float_encoder_tx_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   float_encoder_tx_if.slave bus
);

   logic [31:0] word_s;
   logic        onehot_s;

   state_t      state_r;
   logic [4:0]  cnt_r;
   logic [31:0] shreg_r;
   logic [31:0] num_out_r;
   logic        bit_out_r;
   logic        bit_valid_r;
   logic        done_r;
   logic        err_r;
   logic        ready_r;

   float_compose u_compose (
      .type_in   (bus.type_in),
      .sign_in   (bus.sign_in),
      .exp_in    (bus.exp_in),
      .man_in    (bus.man_in),
      .word      (word_s),
      .onehot_ok (onehot_s)
   );

   // Control FSM, shift counter and serialiser with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 5'd0;
         shreg_r     <= 32'd0;
         num_out_r   <= 32'd0;
         bit_out_r   <= 1'b0;
         bit_valid_r <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         ready_r     <= 1'b1;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start && onehot_s) begin
                  // MSB goes out immediately; the register keeps the remaining 31 bits
                  num_out_r   <= word_s;
                  shreg_r     <= {word_s[30:0], 1'b0};
                  bit_out_r   <= word_s[31];
                  bit_valid_r <= 1'b1;
                  ready_r     <= 1'b0;
                  cnt_r       <= 5'd0;
                  state_r     <= ST_SHIFT;
               end else if (bus.start) begin
                  err_r <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (cnt_r == 5'd31) begin
                  cnt_r       <= 5'd0;
                  bit_out_r   <= 1'b0;
                  bit_valid_r <= 1'b0;
                  done_r      <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  bit_out_r <= shreg_r[31];
                  shreg_r   <= {shreg_r[30:0], 1'b0};
                  cnt_r     <= cnt_r + 5'd1;
               end
            end
            ST_DONE: begin
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               bit_valid_r <= 1'b0;
               bit_out_r   <= 1'b0;
               ready_r     <= 1'b1;
               cnt_r       <= 5'd0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready     = ready_r;
   assign bus.num_out   = num_out_r;
   assign bus.bit_out   = bit_out_r;
   assign bus.bit_valid = bit_valid_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_float_encoder_tx.sv
// Self-checking bench for float_encoder_tx: behavioural timing/compose model,
// per-cycle compare process, directed literal cases and randomized requests.
module tb_float_encoder_tx;
   import float_encoder_tx_pkg::*;

   logic clk;
   logic reset;
   float_encoder_tx_if bus ();

   float_encoder_tx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // model state: phase = cycles since the accepting edge, -1 when idle
   int          m_phase = -1;
   logic [31:0] m_num   = 32'd0;
   logic        m_err   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [4:0] t, input logic s,
                                              input logic [7:0] e, input logic [22:0] m);
      int          ee;
      logic [22:0] mm;
      ee = 0;
      mm = 23'd0;
      if (t == 5'b00010) begin
         ee = int'(e);
         if (ee == 0)   ee = 1;
         if (ee == 255) ee = 254;
         mm = m;
      end else if (t == 5'b00100) begin
         mm = (m == 23'd0) ? 23'd1 : m;
      end else if (t == 5'b01000) begin
         ee = 255;
      end else if (t == 5'b10000) begin
         ee = 255;
         mm = (m == 23'd0) ? 23'h400000 : m;
      end
      return {s, ee[7:0], mm};
   endfunction

   function automatic logic [4:0] classify(input logic [31:0] w);
      if (w[30:23] == 8'h00) return (w[22:0] == 23'd0) ? 5'b00001 : 5'b00100;
      if (w[30:23] == 8'hFF) return (w[22:0] == 23'd0) ? 5'b01000 : 5'b10000;
      return 5'b00010;
   endfunction

   function automatic bit is_onehot(input logic [4:0] t);
      int c;
      c = 0;
      for (int i = 0; i < 5; i++) if (t[i]) c++;
      return c == 1;
   endfunction

   // Reference behaviour: what the outputs must be after each edge
   always @(posedge clk) begin
      if (reset) begin
         m_phase <= -1;
         m_num   <= 32'd0;
         m_err   <= 1'b0;
      end else begin
         m_err <= 1'b0;
         if (m_phase == -1) begin
            if (bus.start && is_onehot(bus.type_in)) begin
               m_phase <= 0;
               m_num   <= model_word(bus.type_in, bus.sign_in, bus.exp_in, bus.man_in);
            end else if (bus.start) begin
               m_err <= 1'b1;
            end
         end else if (m_phase == 33 - 1) begin
            m_phase <= -1;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic e_valid;
         logic e_bit;
         e_valid = (m_phase >= 0) && (m_phase <= 31);
         e_bit   = e_valid ? m_num[31 - m_phase] : 1'b0;
         check("ready",     {31'd0, bus.ready},     {31'd0, m_phase == -1});
         check("bit_valid", {31'd0, bus.bit_valid}, {31'd0, e_valid});
         check("bit_out",   {31'd0, bus.bit_out},   {31'd0, e_bit});
         check("done",      {31'd0, bus.done},      {31'd0, m_phase == 32});
         check("err",       {31'd0, bus.err},       {31'd0, m_err});
         check("num_out",   bus.num_out,            m_num);
      end
   end

   // caller is at a negedge; start is held for exactly one edge
   task automatic send(input logic [4:0] t, input logic s, input logic [7:0] e, input logic [22:0] m);
      bus.start   = 1'b1;
      bus.type_in = t;
      bus.sign_in = s;
      bus.exp_in  = e;
      bus.man_in  = m;
      @(negedge clk);
      bus.start   = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [4:0]  d_t [7] = '{5'b00010, 5'b00010, 5'b00010, 5'b00100, 5'b10000, 5'b01000, 5'b00001};
   logic        d_s [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [7:0]  d_e [7] = '{8'h80, 8'hFF, 8'h00, 8'h55, 8'h12, 8'h34, 8'h99};
   logic [22:0] d_m [7] = '{23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'h1234, 23'h7FFF};
   logic [31:0] d_w [7] = '{32'hC0000000, 32'h7F000000, 32'h00800000, 32'h00000001,
                            32'h7FC00000, 32'hFF800000, 32'h80000000};

   initial begin
      logic [31:0] last_w;
      logic [4:0]  t;
      logic [7:0]  e;
      logic [22:0] m;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.type_in = 5'd0;
      bus.sign_in = 1'b0;
      bus.exp_in  = 8'd0;
      bus.man_in  = 23'd0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_ready",   {31'd0, bus.ready},     32'd1);
      check("rst_num_out", bus.num_out,            32'd0);
      check("rst_bvalid",  {31'd0, bus.bit_valid}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // directed classes with hand-computed words
      for (int i = 0; i < 7; i++) begin
         check("model_pin", model_word(d_t[i], d_s[i], d_e[i], d_m[i]), d_w[i]);
         send(d_t[i], d_s[i], d_e[i], d_m[i]);
         check("lit_num_out", bus.num_out, d_w[i]);
         check("lit_bit31", {31'd0, bus.bit_out}, {31'd0, d_w[i][31]});
         wait_cycles(32);
         check("lit_done", {31'd0, bus.done}, 32'd1);
         wait_cycles(1);
         check("lit_ready", {31'd0, bus.ready}, 32'd1);
      end
      last_w = d_w[6];

      // invalid class code
      send(5'b00011, 1'b1, 8'h40, 23'h1);
      check("inv_err",     {31'd0, bus.err},       32'd1);
      check("inv_ready",   {31'd0, bus.ready},     32'd1);
      check("inv_bvalid",  {31'd0, bus.bit_valid}, 32'd0);
      check("inv_num_out", bus.num_out,            last_w);
      wait_cycles(1);
      check("inv_err_off", {31'd0, bus.err},       32'd0);

      // start re-asserted mid-stream with different inputs
      send(5'b00010, 1'b1, 8'h80, 23'd0);
      wait_cycles(4);
      bus.start   = 1'b1;
      bus.type_in = 5'b01000;
      bus.sign_in = 1'b0;
      bus.exp_in  = 8'h11;
      bus.man_in  = 23'h5A5A5;
      wait_cycles(2);
      bus.start = 1'b0;
      wait_cycles(27);
      check("ign_num_out", bus.num_out, 32'hC0000000);
      check("ign_ready",   {31'd0, bus.ready}, 32'd1);

      // reset sampled at E10 aborts the transfer
      send(5'b10000, 1'b0, 8'h00, 23'h2AAAA);
      wait_cycles(9);
      reset = 1'b1;
      wait_cycles(1);
      reset = 1'b0;
      check("mid_rst_num",    bus.num_out,            32'd0);
      check("mid_rst_bvalid", {31'd0, bus.bit_valid}, 32'd0);
      check("mid_rst_ready",  {31'd0, bus.ready},     32'd1);
      check("mid_rst_bit",    {31'd0, bus.bit_out},   32'd0);
      for (int i = 0; i < 30; i++) begin
         check("mid_rst_nodone", {31'd0, bus.done}, 32'd0);
         @(negedge clk);
      end

      // randomized requests with loopback classification
      for (int i = 0; i < 24; i++) begin
         e = 8'($urandom);
         m = 23'($urandom);
         if ($urandom_range(0, 3) == 0) m = 23'd0;
         if ($urandom_range(0, 4) == 0) e = 8'h00;
         if ($urandom_range(0, 4) == 0) e = 8'hFF;
         if ($urandom_range(0, 5) == 5) begin
            t = ($urandom_range(0, 3) == 0) ? 5'b00000 : (5'($urandom) | 5'b00011);
            send(t, 1'($urandom), e, m);
            wait_cycles(1);
         end else begin
            t = 5'b00001 << $urandom_range(0, 4);
            send(t, 1'($urandom), e, m);
            check("loopback_class", {27'd0, classify(bus.num_out)}, {27'd0, t});
            wait_cycles(33);
         end
      end

      wait_cycles(2);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
